cpu_clken: RTL and testbench
============================

Name: cpu_clken

Overview:
- Parametrised clock-enable and wait-state generator for the Z80 core.
- Derives the pe/ne enables from the master clock at a selectable speed.
- Stretches T-states for memory and I/O cycles by a parametrised number of wait periods.
- Optionally freezes the CPU on video contention requests. Sits between the clock tree and the CPU wrapper, observing the CPU's active-low bus strobes.

Parameters:
- DIV_W, 3: phase counter width; turbo 0 period P = 2^DIV_W master clocks.
- MEM_WAIT, 0: extra T-states inserted per new non-refresh memory cycle (0..15).
- IO_WAIT, 1: extra T-states inserted per new I/O cycle (0..15).

Ports:
- clock  in  1  master clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- turbo  in  2  speed select; P = max(2, 2^(DIV_W-turbo)).
- mreq  in  1  CPU MREQ_n, active-low.
- iorq  in  1  CPU IORQ_n, active-low.
- rfsh  in  1  CPU RFSH_n, active-low.
- contend  in  1  contention request from video, active-high.
- pe  out  1  positive-edge enable, one-clock registered pulse.
- ne  out  1  negative-edge enable, one-clock registered pulse.
- stall  out  1  high while a wait or contention hold is in progress.

Behaviour:
- Reset (asynchronous, while reset=0): ph=0, wcnt=0, turbo_r=0, prev_mem=1, prev_io=1, pe=0, ne=0, stall=0.
- Period: ph counts 0..P-1 using turbo_r.
  - Boundary is the clock where ph==P-1; mid-point is the clock where ph==P/2-1.
  - P is clamped to a minimum of 2; turbo values yielding less than 2 use P=2.
- Normal operation:
  - At mid-point with wcnt==0: ne<=1 for the next clock.
  - At boundary with no hold: pe<=1 for the next clock and ph<=0.
  - pe and ne are otherwise 0. They are never both high together, and never high for two consecutive clocks at P>2.
  - Latency: first pe is at clock P after reset release; first ne is at clock P/2.
- Turbo:
  - turbo_r<=turbo only at boundaries where pe is issued.
  - A change mid-period takes effect from the following period; no runt periods.
- Strobe sampling at every boundary:
  - new_io = !iorq && prev_io.
  - new_mem = !mreq && prev_mem && rfsh.
  - prev_io<=iorq and prev_mem<=mreq are updated at every boundary, including suppressed boundaries.
- Wait insertion (evaluated at the boundary):
  - If wcnt==0 and new_io and IO_WAIT>0: pe is suppressed, wcnt<=IO_WAIT, ph<=0.
  - Else if wcnt==0 and new_mem and MEM_WAIT>0: same, using MEM_WAIT.
  - new_io has priority over new_mem.
  - If wcnt>1: pe is suppressed and wcnt decrements.
  - If wcnt==1: pe is issued and wcnt<=0.
  - ne is suppressed whenever wcnt!=0.
  - Net effect: exactly N extra silent periods before the delayed pe.
- Refresh: a memory cycle with rfsh=0 never triggers a wait.
- stall = (wcnt!=0) or contention hold active; registered.
- Reset mid-stall: all state clears immediately; after release, behaviour is as from power-up.

Optional Feature:
- Macro: CPU_CLKEN_CONTEND_EN.
- Defined:
  - If contend=1 at a boundary, ph holds at P-1, pe is suppressed, and stall=1.
  - The hold releases on the first boundary clock with contend=0; pe is issued then (subject to wait logic).
  - The wait counter does not decrement during a hold.
- Not defined: the contend port is present but ignored; stall reflects waits only.

Test Plan:
- Reset pulse then release, DIV_W=3, turbo=0 -> pe=ne=stall=0 during reset; ne at clock 4 and pe at clock 8, then both every 8 clocks.
- turbo switched 0->2 at ph=2 -> current period completes at 8 clocks, then pe every 2 clocks alternating with ne; turbo=3 also gives period 2.
- IO_WAIT=2, iorq driven low just before a boundary -> pe delayed by 2 periods, no ne in those periods, stall high for those 2 periods; holding iorq low does not retrigger.
- MEM_WAIT=1, mreq low with rfsh=0 -> no wait; mreq low with rfsh=1 -> one extra period.
- CPU_CLKEN_CONTEND_EN defined, contend high for 5 clocks across a boundary -> pe delayed by 5 clocks, ph held at P-1, stall=1; undefined build -> timing unchanged.
- Reset asserted with wcnt=2 -> outputs and wcnt zero asynchronously; normal period resumes after release.

Source files
------------

// File: rtl/cpu_clken_if.sv
// CPU-side bus strobes, speed select and the clock-enable outputs of cpu_clken.
interface cpu_clken_if;
    logic [1:0] turbo;
    logic       mreq;
    logic       iorq;
    logic       rfsh;
    logic       contend;
    logic       pe;
    logic       ne;
    logic       stall;

    modport master (output turbo, mreq, iorq, rfsh, contend, input pe, ne, stall);
    modport slave  (input turbo, mreq, iorq, rfsh, contend, output pe, ne, stall);
endinterface

// File: rtl/cpu_clken.sv
// Z80 pe/ne clock-enable and wait-state generator with selectable speed.
// Define CPU_CLKEN_CONTEND_EN to let video contention freeze the CPU at a boundary.
module cpu_clken #(
    parameter int DIV_W    = 3,
    parameter int MEM_WAIT = 0,
    parameter int IO_WAIT  = 1
) (
    input logic        clock,
    input logic        reset,
    cpu_clken_if.slave bus
);

    logic [DIV_W-1:0] ph, ph_nxt;
    logic [DIV_W-1:0] last, mid, shr;
    logic [3:0]       wcnt, wcnt_nxt;
    logic [1:0]       turbo_r, turbo_nxt;
    logic             prev_mem, prev_io, prev_mem_nxt, prev_io_nxt;
    logic             pe_nxt, ne_nxt, stall_nxt;
    logic             boundary, at_mid, hold, new_io, new_mem;

    // Period is 2^(DIV_W-turbo) clocks, so the last phase is all-ones shifted right;
    // a zero result means P would drop below 2 and is clamped.
    always_comb begin
        shr  = {DIV_W{1'b1}} >> turbo_r;
        last = (shr == '0) ? DIV_W'(1) : shr;
        mid  = last >> 1;
    end

    assign boundary = (ph == last);
    assign at_mid   = (ph == mid);
    assign new_io   = !bus.iorq && prev_io;
    assign new_mem  = !bus.mreq && prev_mem && bus.rfsh;

`ifdef CPU_CLKEN_CONTEND_EN
    assign hold = boundary && bus.contend;
`else
    logic unused_contend;
    assign unused_contend = bus.contend;
    assign hold           = 1'b0;
`endif

    always_comb begin
        ph_nxt       = ph + 1'b1;
        wcnt_nxt     = wcnt;
        turbo_nxt    = turbo_r;
        prev_io_nxt  = prev_io;
        prev_mem_nxt = prev_mem;
        pe_nxt       = 1'b0;
        ne_nxt       = at_mid && (wcnt == '0) && !hold;
        if (hold) begin
            ph_nxt = ph;
        end else if (boundary) begin
            ph_nxt       = '0;
            prev_io_nxt  = bus.iorq;
            prev_mem_nxt = bus.mreq;
            if (wcnt == '0 && new_io && IO_WAIT > 0) begin
                wcnt_nxt = 4'(IO_WAIT);
            end else if (wcnt == '0 && new_mem && MEM_WAIT > 0) begin
                wcnt_nxt = 4'(MEM_WAIT);
            end else if (wcnt > 4'd1) begin
                wcnt_nxt = wcnt - 4'd1;
            end else begin
                wcnt_nxt  = '0;
                pe_nxt    = 1'b1;
                turbo_nxt = bus.turbo;
            end
        end
        stall_nxt = hold || (wcnt_nxt != '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ph        <= '0;
            wcnt      <= '0;
            turbo_r   <= '0;
            prev_mem  <= 1'b1;
            prev_io   <= 1'b1;
            bus.pe    <= 1'b0;
            bus.ne    <= 1'b0;
            bus.stall <= 1'b0;
        end else begin
            ph        <= ph_nxt;
            wcnt      <= wcnt_nxt;
            turbo_r   <= turbo_nxt;
            prev_mem  <= prev_mem_nxt;
            prev_io   <= prev_io_nxt;
            bus.pe    <= pe_nxt;
            bus.ne    <= ne_nxt;
            bus.stall <= stall_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_clken.sv
// Bench for cpu_clken: per-period vector table plus contention and reset-mid-wait sequences.
module tb_cpu_clken;

    logic clock;
    logic reset;
    cpu_clken_if bus ();

    cpu_clken #(.DIV_W(3), .MEM_WAIT(1), .IO_WAIT(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] turbo;
        int         t_at;
        logic       mreq;
        logic       iorq;
        logic       rfsh;
        int         p;
        bit         ne_on;
        bit         pe_on;
        bit         st_mid;
        bit         st_last;
        string      name;
    } row_t;

    row_t       rows [25];
    logic [2:0] sb [$];
    int         checks = 0;
    int         passes = 0;
    int         cycle  = 0;
    logic [1:0] cur_turbo = 2'd0;

    function automatic row_t mk(logic [1:0] t, int ta, logic m, logic io, logic rf, int p,
                                bit n, bit pe, bit smid, bit sl, string nm);
        row_t r;
        r.turbo = t; r.t_at = ta; r.mreq = m; r.iorq = io; r.rfsh = rf; r.p = p;
        r.ne_on = n; r.pe_on = pe; r.st_mid = smid; r.st_last = sl; r.name = nm;
        return r;
    endfunction

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s cycle=%0d got=%b want=%b", nm, cycle, got, want);
    endtask

    // Drive one clock of inputs, queue the outputs expected after the edge, then compare.
    task automatic cyc(input logic [1:0] t, input logic m, input logic io, input logic rf,
                       input logic ct, input logic [2:0] want, input string nm);
        logic [2:0] exp;
        bus.turbo = t; bus.mreq = m; bus.iorq = io; bus.rfsh = rf; bus.contend = ct;
        sb.push_back(want);
        @(posedge clock);
        #1;
        cycle++;
        exp = sb.pop_front();
        check(nm, {5'd0, bus.pe, bus.ne, bus.stall}, {5'd0, exp});
    endtask

    task automatic run_row(input row_t r);
        logic [1:0] t;
        logic [2:0] want;
        for (int k = 1; k <= r.p; k++) begin
            t    = (k >= r.t_at) ? r.turbo : cur_turbo;
            want = {r.pe_on && (k == r.p), r.ne_on && (k == r.p / 2),
                    (k < r.p) ? r.st_mid : r.st_last};
            cyc(t, r.mreq, r.iorq, r.rfsh, 1'b0, want, r.name);
        end
        cur_turbo = r.turbo;
    endtask

    initial begin
        int hold;
        rows[0]  = mk(2'd0, 1, 1, 1, 1, 8, 1, 1, 0, 0, "t0_first");
        rows[1]  = mk(2'd0, 1, 1, 1, 1, 8, 1, 1, 0, 0, "t0_steady");
        rows[2]  = mk(2'd2, 3, 1, 1, 1, 8, 1, 1, 0, 0, "t0to2_mid");
        rows[3]  = mk(2'd2, 1, 1, 1, 1, 2, 1, 1, 0, 0, "t2_a");
        rows[4]  = mk(2'd2, 1, 1, 1, 1, 2, 1, 1, 0, 0, "t2_b");
        rows[5]  = mk(2'd3, 1, 1, 1, 1, 2, 1, 1, 0, 0, "t2to3");
        rows[6]  = mk(2'd3, 1, 1, 1, 1, 2, 1, 1, 0, 0, "t3_clamp");
        rows[7]  = mk(2'd1, 1, 1, 1, 1, 2, 1, 1, 0, 0, "t3to1");
        rows[8]  = mk(2'd1, 1, 1, 1, 1, 4, 1, 1, 0, 0, "t1");
        rows[9]  = mk(2'd0, 1, 1, 1, 1, 4, 1, 1, 0, 0, "t1to0");
        rows[10] = mk(2'd0, 1, 1, 1, 1, 8, 1, 1, 0, 0, "t0_back");
        rows[11] = mk(2'd0, 1, 1, 0, 1, 8, 1, 0, 0, 1, "io_trig");
        rows[12] = mk(2'd0, 1, 1, 0, 1, 8, 0, 0, 1, 1, "io_wait1");
        rows[13] = mk(2'd0, 1, 1, 0, 1, 8, 0, 1, 1, 0, "io_wait2");
        rows[14] = mk(2'd0, 1, 1, 0, 1, 8, 1, 1, 0, 0, "io_held_low");
        rows[15] = mk(2'd0, 1, 1, 1, 1, 8, 1, 1, 0, 0, "io_release");
        rows[16] = mk(2'd0, 1, 0, 1, 0, 8, 1, 1, 0, 0, "mem_refresh");
        rows[17] = mk(2'd0, 1, 1, 1, 1, 8, 1, 1, 0, 0, "mem_idle");
        rows[18] = mk(2'd0, 1, 0, 1, 1, 8, 1, 0, 0, 1, "mem_trig");
        rows[19] = mk(2'd0, 1, 0, 1, 1, 8, 0, 1, 1, 0, "mem_wait1");
        rows[20] = mk(2'd0, 1, 1, 1, 1, 8, 1, 1, 0, 0, "mem_release");
        rows[21] = mk(2'd0, 1, 0, 0, 1, 8, 1, 0, 0, 1, "both_trig");
        rows[22] = mk(2'd0, 1, 0, 0, 1, 8, 0, 0, 1, 1, "both_wait1");
        rows[23] = mk(2'd0, 1, 0, 0, 1, 8, 0, 1, 1, 0, "both_wait2");
        rows[24] = mk(2'd0, 1, 1, 1, 1, 8, 1, 1, 0, 0, "both_release");

        reset = 1'b0;
        bus.turbo = 2'd0; bus.mreq = 1'b1; bus.iorq = 1'b1; bus.rfsh = 1'b1; bus.contend = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_out", {5'd0, bus.pe, bus.ne, bus.stall}, 8'd0);
        @(negedge clock);
        reset = 1'b1;

        foreach (rows[i]) run_row(rows[i]);

        // Contention asserted on the boundary clock for 5 clocks.
`ifdef CPU_CLKEN_CONTEND_EN
        hold = 5;
`else
        hold = 0;
`endif
        for (int k = 1; k <= 16 + hold; k++) begin
            cyc(2'd0, 1'b1, 1'b1, 1'b1, (k >= 8 && k < 13),
                {(k == 8 + hold) || (k == 16 + hold), (k == 4) || (k == 12 + hold),
                 (hold > 0) && (k >= 8) && (k < 8 + hold)}, "contend");
        end

        // Reset in the middle of an I/O wait.
        run_row(rows[11]);
        for (int k = 1; k <= 3; k++) cyc(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b001, "pre_reset_wait");
        #2;
        reset = 1'b0;
        bus.iorq = 1'b1;
        #1;
        check("async_reset_out", {5'd0, bus.pe, bus.ne, bus.stall}, 8'd0);
        check("async_reset_wcnt", {4'd0, dut.wcnt}, 8'd0);
        @(negedge clock);
        reset = 1'b1;
        cycle = 0;
        run_row(rows[0]);
        run_row(rows[1]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
